weight_fifo_loader: RTL and testbench
=====================================

# weight_fifo_loader

Write-side controller for the systolic-array weight FIFO. On `start`, it fetches `FIFO_DEPTH` weight rows from weight SRAM, one row per read, starting at `base_addr`. It presents each row on `w_in` and pulses the all-stage shift enable so the rows ripple into the FIFO. When the load completes, row `base_addr` sits at the FIFO output stage and row `base_addr+FIFO_DEPTH-1` sits at stage 0. It sits between the weight SRAM and the weight FIFO feeding the PE array.

## Interface
Parameters:
- `DATA_WIDTH`, 16, bits per weight element.
- `FIFO_WIDTH`, 16, elements per row (array columns).
- `FIFO_DEPTH`, 16, FIFO stages, equal to rows per load.
- `ADDR_WIDTH`, 16, SRAM row-address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first row address; captured on an accepted `start`.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `mem_req`  out  1  one-cycle read request.
- `mem_addr`  out  ADDR_WIDTH  read row address; valid while `mem_req` is high.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DATA_WIDTH*FIFO_WIDTH  row data; element j is `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `w_in`  out  unpacked `[0:FIFO_WIDTH-1]` of DATA_WIDTH  row driven into FIFO stage 0; element j comes from `mem_rdata` element j.
- `en`  out  FIFO_DEPTH  per-stage shift enables; all bits are always driven equal.

## Operation
- FSM states: IDLE, REQ, WAIT, SHIFT, DONE. Row counter `row`, range 0..FIFO_DEPTH-1.
- IDLE: when `start=1`, capture `base_addr`, clear `row`, go to REQ. `start` is ignored in every other state.
- REQ: `mem_req=1`, `mem_addr = base + row` (modulo 2^ADDR_WIDTH; wraps silently). Go to WAIT.
- WAIT: when `mem_rvalid=1`, register `mem_rdata` into the `w_in` register and go to SHIFT.
- SHIFT: `en` is all ones for exactly this cycle, with `w_in` stable.
  - If `row == FIFO_DEPTH-1`, go to DONE.
  - Otherwise increment `row` and go to REQ.
- DONE: `done=1` for one cycle, then return to IDLE.
- `busy=1` in REQ, WAIT, SHIFT. `busy=0` in IDLE and DONE.
- Only one read is ever outstanding. `mem_rvalid` in any state other than WAIT is ignored.
- `w_in` holds the last shifted row until it is overwritten. It is only meaningful while `en` is high.
- Reset, asynchronous and possibly mid-load:
  - Outputs return immediately to `busy=0`, `done=0`, `mem_req=0`, `mem_addr=0`, `en=0`, `w_in` all zero.
  - FSM returns to IDLE, `row=0`.
  - A partially loaded FIFO is not cleaned up; the next load overwrites it fully.

## Timing
- `start` accepted at edge t: REQ occupies cycle t+1.
- Memory latency L ≥ 1: `mem_rvalid` arrives L cycles after the REQ cycle.
- Row period is L+2 cycles: REQ, L−1 wait cycles, the capture edge, then SHIFT.
- Load of D rows with fixed L: the first REQ is 1 cycle after `start`. The last SHIFT cycle ends D·(L+2) cycles after the first REQ begins. `done` is high in the following cycle.
- Example: D=16, L=1 gives 48 cycles from the first REQ to the `done` cycle.
- The earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `WEIGHT_FIFO_LOADER_ZERO_PAD_EN` defined:
  - Adds input `num_rows` (width `$clog2(FIFO_DEPTH+1)`), captured with `start`.
  - Rows 0..`num_rows`-1 are fetched as above.
  - The remaining rows skip REQ/WAIT and shift `w_in` = 0, one SHIFT cycle per row, with `mem_req` low.
  - `num_rows=0` performs FIFO_DEPTH zero shifts with no reads.
  - `num_rows>FIFO_DEPTH` is clamped to FIFO_DEPTH.
- Macro undefined: the port is absent and every load fetches all FIFO_DEPTH rows.

## Test plan
- Reset values: hold `rstn=0`, then release → all outputs zero and FSM in IDLE; `start` one cycle later → `mem_req` high with `mem_addr` = `base_addr`.
- Full load: D=4, L=1, `base_addr=0x10`, row k data = k+1 in every element → `mem_addr` 0x10..0x13, four single-cycle `en=4'b1111` pulses, `done` 12 cycles after the first REQ; a modelled FIFO output reads 1 and stage 0 holds 4.
- Variable latency: `mem_rvalid` delayed 1, 3, 5, 2 cycles on successive rows → `en` pulses exactly once per row, only in the cycle after each `mem_rvalid`; no second `mem_req` is issued before the prior data returns.
- Wrap and ignores: `base_addr=0xFFFE`, D=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; `start` pulsed mid-load and a spurious `mem_rvalid` in REQ → no effect.
- Reset mid-load: assert `rstn=0` during the WAIT of row 2 → `busy`, `en`, `mem_req` drop immediately; a new `start` completes a clean load with `done` asserted once.
- With `WEIGHT_FIFO_LOADER_ZERO_PAD_EN`: `num_rows=2`, D=4 → exactly 2 reads, 4 `en` pulses with the last two carrying `w_in`=0; `num_rows=0` → 4 zero shifts, `done` 5 cycles after `start`.

Source files
------------

// File: rtl/weight_fifo_loader.sv
// Weight SRAM -> systolic weight FIFO loader: fetches FIFO_DEPTH rows and ripples them into the FIFO.
// Optional build macro WEIGHT_FIFO_LOADER_ZERO_PAD_EN adds num_rows; rows past num_rows shift in zeros.
module weight_fifo_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  num_rows,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             mem_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_rvalid,
  input  logic [DATA_WIDTH*FIFO_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0]            w_in [0:FIFO_WIDTH-1],
  output logic [FIFO_DEPTH-1:0]            en
);

  localparam int RW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                          state_q;
  logic [ADDR_WIDTH-1:0]           base_q;
  logic [RW-1:0]                   row_q;
  logic [DATA_WIDTH*FIFO_WIDTH-1:0] wdata_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            mem_req_q;
  logic [ADDR_WIDTH-1:0]           mem_addr_q;
  logic                            en_q;

  logic [RW-1:0] row_d;
  logic          last_row;
  logic          fetch_next;

  assign row_d    = row_q + RW'(1);
  assign last_row = (row_q == RW'(FIFO_DEPTH - 1));

`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
  logic [RW-1:0] nrows_q;
  logic [RW-1:0] nrows_clamped;

  assign nrows_clamped = (num_rows > RW'(FIFO_DEPTH)) ? RW'(FIFO_DEPTH) : num_rows;
  assign fetch_next    = (row_d < nrows_q);
`else
  assign fetch_next = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      row_q      <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      en_q       <= 1'b0;
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
      nrows_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            row_q  <= '0;
            busy_q <= 1'b1;
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
            nrows_q <= nrows_clamped;
            if (nrows_clamped == '0) begin
              // nothing to fetch: go straight to zero shifts
              wdata_q <= '0;
              en_q    <= 1'b1;
              state_q <= S_SHIFT;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= base_addr;
              state_q    <= S_REQ;
            end
`else
            mem_req_q  <= 1'b1;
            mem_addr_q <= base_addr;
            state_q    <= S_REQ;
`endif
          end
        end

        S_REQ: begin
          mem_req_q <= 1'b0;
          state_q   <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            wdata_q <= mem_rdata;
            en_q    <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (last_row) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q <= row_d;
            if (fetch_next) begin
              en_q       <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= base_q + ADDR_WIDTH'(row_d);
              state_q    <= S_REQ;
            end else begin
              // padding row: keep en high and shift a zero row next cycle
              wdata_q <= '0;
              state_q <= S_SHIFT;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign en       = {FIFO_DEPTH{en_q}};

  for (genvar j = 0; j < FIFO_WIDTH; j++) begin : g_win
    assign w_in[j] = wdata_q[j*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Scoreboard bench for weight_fifo_loader: memory model with per-row latency, FIFO model, timing checks.
module tb_weight_fifo_loader;

  localparam int DW = 8;
  localparam int FW = 4;
  localparam int D  = 4;
  localparam int AW = 16;
  localparam int RW = $clog2(D + 1);

  typedef struct {
    logic [DW*FW-1:0] data;
    bit               from_mem;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic              busy, done, mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_rvalid = 1'b0;
  logic [DW*FW-1:0]  mem_rdata = '0;
  logic [DW-1:0]     w_in [0:FW-1];
  logic [D-1:0]      en;
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
  logic [RW-1:0]     num_rows = '0;
`endif

  weight_fifo_loader #(
    .DATA_WIDTH(DW), .FIFO_WIDTH(FW), .FIFO_DEPTH(D), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
    .num_rows(num_rows),
`endif
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .w_in(w_in), .en(en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            lat_tab[$];
  logic [DW*FW-1:0] fifo_m [0:D-1];

  int cyc = 0, start_cyc = -1, done_cyc = -1;
  int done_cnt = 0, req_cnt = 0, en_cnt = 0;
  int pend = 0;
  logic [AW-1:0] pend_addr = '0;
  bit outstanding = 0, en_prev = 0, spur = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*FW-1:0] row_data(input logic [AW-1:0] a);
    logic [DW*FW-1:0] r;
    for (int j = 0; j < FW; j++) r[j*DW +: DW] = DW'(a[7:0] + 8'(j * 37) + 8'd1);
    return r;
  endfunction

  function automatic logic [DW*FW-1:0] win_packed();
    logic [DW*FW-1:0] r;
    for (int j = 0; j < FW; j++) r[j*DW +: DW] = w_in[j];
    return r;
  endfunction

  // Monitor and memory model, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        pend = 0; mem_rvalid = 1'b0; outstanding = 0; en_prev = 0;
      end else begin
        if (en !== '0) begin
          exp_t e;
          check("en_all_ones", en, {D{1'b1}});
          en_cnt++;
          if (exp_q.size() == 0) check("en_unexpected", 0, 1);
          else begin
            e = exp_q.pop_front();
            check("w_in_row", win_packed(), e.data);
            if (e.from_mem) begin
              check("en_after_rvalid", mem_rvalid, 1);
              check("en_single_pulse", en_prev, 0);
            end
          end
          for (int s = D - 1; s > 0; s--) fifo_m[s] = fifo_m[s-1];
          fifo_m[0] = win_packed();
        end
        en_prev = (en !== '0);
        if (mem_req) begin
          req_cnt++;
          check("one_outstanding", outstanding, 0);
          outstanding = 1;
          if (exp_addr_q.size() == 0) check("req_unexpected", 0, 1);
          else check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        mem_rvalid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = row_data(pend_addr);
            outstanding = 0;
          end
        end
        if (mem_req) begin
          pend = (lat_tab.size() > 0) ? lat_tab.pop_front() : 1;
          pend_addr = mem_addr;
          if (spur) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hDEADBEEF;
            spur = 0;
          end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (start && !busy && !done) start_cyc = cyc;
      end
    end
  end

  task automatic run_load(input logic [AW-1:0] b, input int l0, input int l1, input int l2,
                          input int l3, input int n, input bit inject);
    int la[4];
    int nf, expc, d0;
    la = '{l0, l1, l2, l3};
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
    nf = (n > D) ? D : n;
`else
    nf = D;
`endif
    expc = 1;
    for (int k = 0; k < D; k++) begin
      if (k < nf) begin
        exp_addr_q.push_back(b + AW'(k));
        exp_q.push_back('{row_data(b + AW'(k)), 1'b1});
        lat_tab.push_back(la[k]);
        expc += la[k] + 2;
      end else begin
        exp_q.push_back('{'0, 1'b0});
        expc += 1;
      end
    end
    req_cnt = 0; en_cnt = 0; d0 = done_cnt; start_cyc = -1; spur = inject;
    base_addr = b;
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
    num_rows = RW'(n);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      if (inject && i == 3) begin
        start = 1'b1;
        base_addr = 16'h1234;
      end else start = 1'b0;
    end
    start = 1'b0;
    check("load_done", done_cnt - d0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check("en_count", en_cnt, D);
    check("req_count", req_cnt, nf);
    check("done_latency", done_cyc - start_cyc, expc);
    check("sb_rows_left", exp_q.size(), 0);
    check("sb_addr_left", exp_addr_q.size(), 0);
    check("fifo_out", fifo_m[D-1], (nf > 0) ? row_data(b) : '0);
    check("fifo_stage0", fifo_m[0], (nf == D) ? row_data(b + AW'(D - 1)) : '0);
  endtask

  initial begin
    int d0;
    for (int s = 0; s < D; s++) fifo_m[s] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_en", en, 0);
    check("rst_w_in", win_packed(), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    run_load(16'h0010, 1, 1, 1, 1, D, 1'b0);
    run_load(16'h0100, 1, 3, 5, 2, D, 1'b0);
    run_load(16'hFFFE, 1, 1, 1, 1, D, 1'b1);

    // Reset during the WAIT of row 2.
    for (int k = 0; k < D; k++) begin
      exp_addr_q.push_back(16'h0200 + AW'(k));
      exp_q.push_back('{row_data(16'h0200 + AW'(k)), 1'b1});
      lat_tab.push_back(5);
    end
    req_cnt = 0; d0 = done_cnt;
    base_addr = 16'h0200;
`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
    num_rows = RW'(D);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && req_cnt < 3; i++) @(posedge clk);
    #1;
    check("reach_row2", req_cnt, 3);
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", en, 0);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_w_in", win_packed(), 0);
    exp_q.delete(); exp_addr_q.delete(); lat_tab.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_load(16'h0300, 1, 2, 1, 2, D, 1'b0);

`ifdef WEIGHT_FIFO_LOADER_ZERO_PAD_EN
    run_load(16'h0400, 1, 1, 1, 1, 2, 1'b0);
    run_load(16'h0500, 1, 1, 1, 1, 0, 1'b0);
    run_load(16'h0600, 2, 1, 1, 1, 6, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
